// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one 8-bit ALU between two requesters.
// One request is accepted in IDLE. Mul/div then spend a programmable number of
// wait cycles. The registered result is held on a single tagged response
// channel until the consumer accepts it.
module alu_arbiter #(
   parameter int N       = 8,
   parameter int MUL_CYC = 2,
   parameter int DIV_CYC = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [2:0]     req_op0,
   input  logic [2:0]     req_op1,
   input  logic [N-1:0]   req_a0,
   input  logic [N-1:0]   req_a1,
   input  logic [N-1:0]   req_b0,
   input  logic [N-1:0]   req_b1,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic           resp_id,
   output logic [2*N-1:0] resp_data,
   output logic           resp_err,
   output logic           busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state_reg, state_next;
   logic [3:0]     cnt_reg, cnt_next;
   logic           last_grant_reg, last_grant_next;
   logic [2:0]     op_reg;
   logic [N-1:0]   a_reg, b_reg;
   logic           id_reg;
   logic           resp_id_reg;
   logic [2*N-1:0] resp_data_reg;
   logic           resp_err_reg;

   logic           grant;
   logic           accept;
   logic           capture;
   logic [3:0]     load_cnt;
   logic [2:0]     op_arr [2];
   logic [N-1:0]   a_arr  [2];
   logic [N-1:0]   b_arr  [2];
   logic [2:0]     sel_op;
   logic [N-1:0]   sel_a, sel_b;
   logic [2:0]     alu_op;
   logic [N-1:0]   alu_a, alu_b;
   logic           alu_id;
   logic [2*N-1:0] a_ext, b_ext;
   logic [2*N-1:0] alu_res;
   logic           alu_err;

   assign op_arr[0] = req_op0;
   assign op_arr[1] = req_op1;
   assign a_arr[0]  = req_a0;
   assign a_arr[1]  = req_a1;
   assign b_arr[0]  = req_b0;
   assign b_arr[1]  = req_b1;

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      if (req_valid == 2'b11) grant = ~last_grant_reg;
      else                    grant = req_valid[1];
   end

   assign sel_op = op_arr[grant];
   assign sel_a  = a_arr[grant];
   assign sel_b  = b_arr[grant];

   // Only the granted requester sees ready, and only while idle.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && (grant == 1'(gi)) && req_valid[gi];
   end

   assign accept = |(req_valid & req_ready);

   // The ALU works on the live granted payload in IDLE (zero-wait ops finish at
   // the accept edge) and on the latched payload once the op has been accepted.
   assign alu_op = (state_reg == IDLE) ? sel_op : op_reg;
   assign alu_a  = (state_reg == IDLE) ? sel_a  : a_reg;
   assign alu_b  = (state_reg == IDLE) ? sel_b  : b_reg;
   assign alu_id = (state_reg == IDLE) ? grant  : id_reg;
   assign a_ext  = {{N{1'b0}}, alu_a};
   assign b_ext  = {{N{1'b0}}, alu_b};

   // Shared combinational ALU on zero-extended operands.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (alu_op)
         OP_ADD:  alu_res = a_ext + b_ext;
         OP_AND:  alu_res = a_ext & b_ext;
         OP_SUB:  alu_res = a_ext - b_ext;
         OP_OR:   alu_res = a_ext | b_ext;
         OP_XOR:  alu_res = a_ext ^ b_ext;
         OP_MUL:  alu_res = a_ext * b_ext;
         OP_DIV: begin
            if (alu_b == '0) begin
               alu_res = '1;
               alu_err = 1'b1;
            end else begin
               alu_res = a_ext / b_ext;
            end
         end
         default: alu_res = (alu_a < alu_b) ? a_ext : b_ext;
      endcase
   end

   // Wait-cycle count for the op being accepted; divide-by-zero answers at once.
   always_comb begin
      load_cnt = '0;
      if (sel_op == OP_MUL)                       load_cnt = 4'(MUL_CYC);
      else if (sel_op == OP_DIV && sel_b != '0)   load_cnt = 4'(DIV_CYC);
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold result in RESP.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_grant_next = last_grant_reg;
      capture         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               last_grant_next = grant;
               cnt_next        = load_cnt;
               if (load_cnt == '0) begin
                  state_next = RESP;
                  capture    = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               cnt_next   = '0;
               state_next = RESP;
               capture    = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, counter and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_grant_reg <= last_grant_next;
      end
   end

   // Operand latch on accept and result capture on entry to RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= 1'b0;
         resp_id_reg   <= 1'b0;
         resp_data_reg <= '0;
         resp_err_reg  <= 1'b0;
      end else begin
         if (accept) begin
            op_reg <= sel_op;
            a_reg  <= sel_a;
            b_reg  <= sel_b;
            id_reg <= grant;
         end
         if (capture) begin
            resp_id_reg   <= alu_id;
            resp_data_reg <= alu_res;
            resp_err_reg  <= alu_err;
         end
      end
   end

   assign resp_valid = (state_reg == RESP);
   assign busy       = (state_reg != IDLE);
   assign resp_id    = resp_id_reg;
   assign resp_data  = resp_data_reg;
   assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a cycle-level reference model that
// predicts grants, response timing and results; literal checks pin the model.
module tb_alu_arbiter;

   localparam int N       = 8;
   localparam int MUL_CYC = 2;
   localparam int DIV_CYC = 4;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] AND = 3'b001;
   localparam logic [2:0] SUB = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] MUL = 3'b101;
   localparam logic [2:0] DIV = 3'b110;
   localparam logic [2:0] MIN = 3'b111;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2:0]     req_op0, req_op1;
   logic [N-1:0]   req_a0, req_a1, req_b0, req_b1;
   logic           resp_valid;
   logic           resp_ready;
   logic           resp_id;
   logic [2*N-1:0] resp_data;
   logic           resp_err;
   logic           busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic        m_pend = 1'b0;
   int          m_rc   = 0;
   logic        m_last = 1'b1;
   logic        m_id   = 1'b0;
   logic [15:0] m_data = 16'h0;
   logic        m_err  = 1'b0;

   alu_arbiter #(.N(N), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op0    (req_op0),
      .req_op1    (req_op1),
      .req_a0     (req_a0),
      .req_a1     (req_a1),
      .req_b0     (req_b0),
      .req_b1     (req_b1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [2:0] op, input int a, input int b);
      int r;
      case (op)
         ADD:     r = a + b;
         AND:     r = a & b;
         SUB:     r = a - b;
         OR:      r = a | b;
         XOR:     r = a ^ b;
         MUL:     r = a * b;
         DIV:     r = (b == 0) ? 65535 : a / b;
         default: r = (a < b) ? a : b;
      endcase
      return 16'(r);
   endfunction

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      logic [1:0] e_ready;
      logic       g;
      logic       e_rv;
      logic [2:0] op;
      int         a, b, lat;
      if (!rst_n) begin
         chk("rst req_ready", 32'(req_ready), 0);
         chk("rst resp_valid", 32'(resp_valid), 0);
         chk("rst busy", 32'(busy), 0);
         chk("rst resp_id", 32'(resp_id), 0);
         chk("rst resp_data", 32'(resp_data), 0);
         chk("rst resp_err", 32'(resp_err), 0);
         m_pend = 1'b0;
         m_last = 1'b1;
      end else begin
         e_ready = 2'b00;
         g       = 1'b0;
         if (!m_pend) begin
            if (req_valid == 2'b11) g = ~m_last;
            else                    g = req_valid[1];
            e_ready[g] = req_valid[g];
         end
         e_rv = m_pend && (cyc >= m_rc);
         chk("model req_ready", 32'(req_ready), 32'(e_ready));
         chk("model resp_valid", 32'(resp_valid), 32'(e_rv));
         chk("model busy", 32'(busy), 32'(m_pend));
         if (e_rv) begin
            chk("model resp_id", 32'(resp_id), 32'(m_id));
            chk("model resp_data", 32'(resp_data), 32'(m_data));
            chk("model resp_err", 32'(resp_err), 32'(m_err));
         end
         if (!m_pend && e_ready != 2'b00) begin
            op  = g ? req_op1 : req_op0;
            a   = g ? int'(req_a1) : int'(req_a0);
            b   = g ? int'(req_b1) : int'(req_b0);
            lat = (op == MUL) ? MUL_CYC : ((op == DIV && b != 0) ? DIV_CYC : 0);
            m_pend = 1'b1;
            m_rc   = cyc + 1 + lat;
            m_last = g;
            m_id   = g;
            m_data = ref_alu(op, a, b);
            m_err  = (op == DIV) && (b == 0);
         end else if (e_rv && resp_ready) begin
            m_pend = 1'b0;
         end
      end
      cyc++;
   end

   // One request from requester id; checks latency and the literal result.
   task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_d,
                        input logic exp_e, input int extra);
      int n;
      int lat;
      if (id == 0) begin
         req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10;
      end
      n = 0;
      @(negedge clk);
      while (!req_ready[id] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue accept", 32'(req_ready[id]), 1);
      @(posedge clk);
      #1 req_valid = 2'b00;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 40);
      chk("issue latency", lat, 1 + extra);
      chk("issue data", 32'(resp_data), 32'(exp_d));
      chk("issue err", 32'(resp_err), 32'(exp_e));
      chk("issue id", 32'(resp_id), id);
      $display("op=%0d id=%0d a=%0d b=%0d -> data=%0h err=%0b lat=%0d", op, id, a, b,
               resp_data, resp_err, lat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, got;
      rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
      req_op0 = ADD; req_op1 = ADD; req_a0 = 0; req_a1 = 0; req_b0 = 0; req_b1 = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // tie and fairness: both requesters hold valid, grants must alternate from 0
      req_op0 = AND; req_a0 = 8'hF0; req_b0 = 8'h3C;
      req_op1 = AND; req_a1 = 8'h0F; req_b1 = 8'hFF;
      req_valid = 2'b11;
      got = 0; n = 0;
      while (got < 6 && n < 60) begin
         @(negedge clk);
         n++;
         chk("fair onehot", 32'(req_ready == 2'b11), 0);
         if (resp_valid) begin
            chk("fair id", 32'(resp_id), got % 2);
            chk("fair data", 32'(resp_data), (got % 2 == 1) ? 32'h000F : 32'h0030);
            $display("fair resp %0d id=%0d data=%0h", got, resp_id, resp_data);
            got++;
         end
      end
      chk("fair count", got, 6);
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(posedge clk);
      #1;

      issue(0, ADD, 8'd200, 8'd100, 16'd300, 1'b0, 0);
      issue(1, MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, MUL_CYC);
      issue(0, DIV, 8'd100, 8'd7, 16'd14, 1'b0, DIV_CYC);
      issue(1, DIV, 8'd9, 8'd0, 16'hFFFF, 1'b1, 0);
      issue(0, SUB, 8'd3, 8'd5, 16'hFFFE, 1'b0, 0);
      issue(1, MIN, 8'd7, 8'd4, 16'd4, 1'b0, 0);
      issue(0, OR, 8'hA0, 8'h05, 16'h00A5, 1'b0, 0);
      issue(1, XOR, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 0);
      issue(0, DIV, 8'd255, 8'd1, 16'd255, 1'b0, DIV_CYC);
      issue(1, MUL, 8'd0, 8'd77, 16'd0, 1'b0, MUL_CYC);

      // backpressure: result must hold while resp_ready is low
      resp_ready = 1'b0;
      req_op0 = ADD; req_a0 = 8'd10; req_b0 = 8'd20; req_valid = 2'b01;
      n = 0;
      @(negedge clk);
      while (!req_ready[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp accept", 32'(req_ready), 32'(2'b01));
      @(posedge clk);
      #1 req_op1 = XOR; req_a1 = 8'h55; req_b1 = 8'hFF; req_valid = 2'b10;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp valid", 32'(resp_valid), 1);
         chk("bp data", 32'(resp_data), 30);
         chk("bp id", 32'(resp_id), 0);
         chk("bp req_ready", 32'(req_ready), 0);
         $display("bp hold %0d valid=%0b data=%0d", k, resp_valid, resp_data);
         @(negedge clk);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp idle busy", 32'(busy), 0);
      chk("bp next accept", 32'(req_ready), 32'(2'b10));
      @(posedge clk);
      #1 req_valid = 2'b00;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp next data", 32'(resp_data), 32'h00AA);
      chk("bp next id", 32'(resp_id), 1);
      $display("bp next resp id=%0d data=%0h", resp_id, resp_data);
      @(posedge clk);
      #1;

      // reset in the middle of a divide's wait phase
      req_op0 = DIV; req_a0 = 8'd100; req_b0 = 8'd7; req_valid = 2'b01;
      n = 0;
      @(negedge clk);
      while (!req_ready[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(posedge clk);
      #1;
      chk("mid busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("async resp_valid", 32'(resp_valid), 0);
      chk("async busy", 32'(busy), 0);
      chk("async req_ready", 32'(req_ready), 0);
      chk("async resp_data", 32'(resp_data), 0);
      chk("async resp_id", 32'(resp_id), 0);
      chk("async resp_err", 32'(resp_err), 0);
      $display("reset mid-op busy=%0b resp_valid=%0b data=%0h", busy, resp_valid, resp_data);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("post rst no resp", 32'(resp_valid), 0);
         chk("post rst idle", 32'(busy), 0);
      end
      @(posedge clk);
      #1 req_op0 = ADD; req_a0 = 8'd1; req_b0 = 8'd2;
      req_op1 = ADD; req_a1 = 8'd3; req_b1 = 8'd4; req_valid = 2'b11;
      @(negedge clk);
      chk("first tie after rst", 32'(req_ready), 32'(2'b01));
      @(posedge clk);
      #1 req_valid = 2'b00;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tie resp id", 32'(resp_id), 0);
      chk("tie resp data", 32'(resp_data), 3);
      $display("tie after reset id=%0d data=%0d", resp_id, resp_data);
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
